data_capture_buffer: RTL and testbench
======================================

# data_capture_buffer

Parametrised frame-capture buffer and successor to the fixed 16-bit × 8 start-triggered buffer. After a start pulse it collects DEPTH words of DATA_W bits, qualified by a per-word valid, into a working register. It then publishes the completed frame atomically to a double-buffered output, so downstream logic never sees a partially filled frame. It sits between the stimulus/data source and any consumer that reads a whole frame at once.

## Interface
- DATA_W, 16, width of one data word (≥1)
- DEPTH, 8, words per frame (≥2)
- CNT_W, $clog2(DEPTH+1), width of count output
- clock  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- data_start  in  1  frame start request, sampled on posedge
- data_valid  in  1  qualifies data in FILL
- data  in  DATA_W  input word
- buffer  out  DATA_W*DEPTH  last completed frame; word i at [i*DATA_W +: DATA_W], word 0 in LSBs
- buffer_valid  out  1  high once at least one frame has completed since reset
- busy  out  1  high while in FILL
- done  out  1  one-cycle pulse: buffer just updated
- count  out  CNT_W  words accepted in current or most recent frame
- start_ignored  out  1  one-cycle pulse: data_start seen while busy

## Operation
- States: IDLE, FILL.
- IDLE: data_start=1 at an edge -> FILL, count←0, write index←0. data_valid is ignored in IDLE.
- FILL: each edge with data_valid=1 writes data into working slice at the index, then index++ and count++. An edge with data_valid=0 is a stall with no change; there is no timeout.
- Last word (index==DEPTH-1 with data_valid=1): at that same edge, buffer←{data, working[DEPTH-2:0]}, done←1, buffer_valid←1, and the state returns to IDLE.
- data_start=1 in FILL: the frame continues unaffected and start_ignored pulses the next cycle. This includes the edge that accepts the last word.
- The working register is internal only. buffer changes only at frame completion, so a partial frame is never visible.
- count holds DEPTH after completion until the next accepted start.

## Timing
- Reset values: buffer=0, buffer_valid=0, busy=0, done=0, count=0, start_ignored=0, state=IDLE, working register=0.
- Reset has priority over every other input. Reset mid-FILL discards the partial frame and also clears buffer and buffer_valid.
- Start accepted at edge k: busy=1 from k; the earliest word is captured at edge k+1, never at edge k.
- With data_valid held high, the last word lands at edge k+DEPTH. In the cycle after k+DEPTH: done=1, busy=0, and buffer shows the new frame.
- Back-to-back: data_start asserted in the done cycle is accepted. The minimum frame period is DEPTH+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package data_buffer_pkg holds the state encodings (IDLE, FILL) and a function computing CNT_W from DEPTH.
- One sub-module, capture_index_counter (params DEPTH, CNT_W), contains:
  - inputs clear and inc
  - outputs index and last (index==DEPTH-1)
- The top level contains the FSM, the working register, the output shadow register, and the pulse flags.

## Test plan
All scenarios use DATA_W=16, DEPTH=8.
- Reset then idle: drive data_valid=1 with data=0xFFFF and no start for 20 cycles -> buffer=0, buffer_valid=0, done never pulses, count=0.
- Continuous frame: start at edge k, data=0x1000+n on edge k+1+n -> done in cycle after k+8, buffer word i=0x1000+i, count=8, busy low.
- Stalls: valid low on alternate cycles, words 0xA0..0xA7 -> same frame contents, done 16 cycles after start, and buffer keeps the previous frame until then.
- Start while busy: pulse data_start at word 3 and at the last-word edge -> start_ignored pulses twice, frame contents are unchanged, and the state is IDLE afterwards.
- Back-to-back: second start in the done cycle with frame 0xB0..0xB7 -> second done exactly 9 cycles after first done, and buffer switches atomically between frames.
- Reset mid-fill: assert reset after 5 words of a second frame -> next cycle buffer=0, buffer_valid=0, count=0, busy=0; a fresh frame afterwards completes normally.

Source files
------------

// File: rtl/data_buffer_pkg.sv
// Shared types for the frame-capture buffer: FSM state encoding and count-width helper.
package data_buffer_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  // Width needed to hold the values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/capture_index_counter.sv
// Write-slot index for the working register; wraps to 0 after the last slot.
// Single cycle update, clear wins over inc.
module capture_index_counter #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_index,
  output logic             o_last
);

  logic [CNT_W-1:0] r_index;
  logic             w_last;

  assign w_last  = (r_index == CNT_W'(DEPTH - 1));
  assign o_index = r_index;
  assign o_last  = w_last;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_index <= '0;
    end else if (i_inc) begin
      r_index <= w_last ? '0 : r_index + CNT_W'(1);
    end
  end

endmodule

// File: rtl/data_capture_buffer.sv
// Collects DEPTH valid-qualified words after a start pulse, then publishes the whole
// frame atomically to o_buffer; all outputs are registered.
module data_capture_buffer
  import data_buffer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = cnt_width(DEPTH)
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_data_start,
  input  logic                    i_data_valid,
  input  logic [DATA_W-1:0]       i_data,
  output logic [DATA_W*DEPTH-1:0] o_buffer,
  output logic                    o_buffer_valid,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [CNT_W-1:0]        o_count,
  output logic                    o_start_ignored
);

  state_t r_state;
  state_t w_next_state;

  logic [DEPTH-1:0][DATA_W-1:0] r_working;
  logic [DEPTH-1:0][DATA_W-1:0] w_frame;
  logic [DATA_W*DEPTH-1:0]      r_buffer;
  logic                         r_buffer_valid;
  logic                         r_done;
  logic                         r_start_ignored;
  logic [CNT_W-1:0]             r_count;

  logic             w_start_accept;
  logic             w_word_accept;
  logic             w_last_accept;
  logic [CNT_W-1:0] w_index;
  logic             w_last;

  assign w_start_accept = (r_state == S_IDLE) && i_data_start;
  assign w_word_accept  = (r_state == S_FILL) && i_data_valid;
  assign w_last_accept  = w_word_accept && w_last;

  capture_index_counter #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_index (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (w_start_accept),
    .i_inc   (w_word_accept),
    .o_index (w_index),
    .o_last  (w_last)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_data_start) w_next_state = S_FILL;
      S_FILL:  if (w_last_accept) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // The completed frame takes the incoming word directly in the top slot, so the
  // publish happens on the same edge that accepts the last word.
  always_comb begin
    w_frame          = r_working;
    w_frame[DEPTH-1] = i_data;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_working       <= '0;
      r_buffer        <= '0;
      r_buffer_valid  <= 1'b0;
      r_done          <= 1'b0;
      r_start_ignored <= 1'b0;
      r_count         <= '0;
    end else begin
      r_state         <= w_next_state;
      r_done          <= w_last_accept;
      r_start_ignored <= (r_state == S_FILL) && i_data_start;
      if (w_start_accept) begin
        r_count <= '0;
      end
      if (w_word_accept) begin
        r_count <= r_count + CNT_W'(1);
        for (int i = 0; i < DEPTH; i++) begin
          if (w_index == CNT_W'(i)) r_working[i] <= i_data;
        end
      end
      if (w_last_accept) begin
        r_buffer       <= w_frame;
        r_buffer_valid <= 1'b1;
      end
    end
  end

  assign o_buffer        = r_buffer;
  assign o_buffer_valid  = r_buffer_valid;
  assign o_busy          = (r_state == S_FILL);
  assign o_done          = r_done;
  assign o_count         = r_count;
  assign o_start_ignored = r_start_ignored;

endmodule

// File: tb/tb_data_capture_buffer.sv
// Directed bench for data_capture_buffer with a queue-based frame model checked every cycle.
module tb_data_capture_buffer;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    start = 1'b0;
  logic                    valid = 1'b0;
  logic [DATA_W-1:0]       din = '0;
  logic [DATA_W*DEPTH-1:0] o_buffer;
  logic                    o_buffer_valid, o_busy, o_done, o_start_ignored;
  logic [CNT_W-1:0]        o_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_pulses = 0;
  int si_pulses = 0;
  int last_done_edge = -1;
  bit model_on = 1'b0;

  data_capture_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_data_start    (start),
    .i_data_valid    (valid),
    .i_data          (din),
    .o_buffer        (o_buffer),
    .o_buffer_valid  (o_buffer_valid),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_count         (o_count),
    .o_start_ignored (o_start_ignored)
  );

  always #5 clk = ~clk;

  // Frame model: words collected in a queue, published whole when DEPTH are in.
  logic [DATA_W-1:0]       m_q[$];
  logic [DATA_W*DEPTH-1:0] m_buf;
  bit                      m_busy, m_valid, m_done, m_si;
  int                      m_count;

  task automatic cmp(input string name, input logic [DATA_W*DEPTH-1:0] act,
                     input logic [DATA_W*DEPTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        model_on = 1'b1;
        m_q.delete();
        m_buf = '0; m_busy = 0; m_valid = 0; m_done = 0; m_si = 0; m_count = 0;
      end else if (model_on) begin
        m_done = 0;
        m_si   = 0;
        if (!m_busy) begin
          if (start) begin
            m_busy = 1; m_count = 0; m_q.delete();
          end
        end else begin
          if (start) m_si = 1;
          if (valid) begin
            m_q.push_back(din);
            m_count = m_q.size();
            if (m_q.size() == DEPTH) begin
              for (int i = 0; i < DEPTH; i++) m_buf[i*DATA_W +: DATA_W] = m_q[i];
              m_valid = 1; m_done = 1; m_busy = 0;
            end
          end
        end
      end
      #1;
      if (model_on) begin
        cmp("buffer", o_buffer, m_buf);
        cmp("buffer_valid", o_buffer_valid, m_valid);
        cmp("busy", o_busy, m_busy);
        cmp("done", o_done, m_done);
        cmp("count", o_count, m_count);
        cmp("start_ignored", o_start_ignored, m_si);
        if (o_done === 1'b1) begin
          done_pulses++;
          last_done_edge = cyc;
        end
        if (o_start_ignored === 1'b1) si_pulses++;
      end
    end
  end

  task automatic step(input logic s, input logic v, input logic [DATA_W-1:0] d);
    @(negedge clk);
    start = s; valid = v; din = d;
  endtask

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic lit_frame(input string name, input int base);
    for (int i = 0; i < DEPTH; i++)
      lit(name, int'(o_buffer[i*DATA_W +: DATA_W]), base + i);
  endtask

  int ks, d1, si0;

  initial begin
    // Reset, then idle with valid data and no start.
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    for (int n = 0; n < 20; n++) step(1'b0, 1'b1, 16'hFFFF);
    @(negedge clk);
    lit("idle_buffer_w0", int'(o_buffer[15:0]), 0);
    lit("idle_buffer_valid", int'(o_buffer_valid), 0);
    lit("idle_count", int'(o_count), 0);
    lit("idle_done_pulses", done_pulses, 0);

    // Continuous frame.
    step(1'b1, 1'b0, '0); ks = cyc + 1;
    for (int n = 0; n < DEPTH; n++) step(1'b0, 1'b1, 16'(16'h1000 + n));
    step(1'b0, 1'b0, '0);
    lit("cont_done_edge", last_done_edge - ks, 8);
    lit("cont_done", int'(o_done), 1);
    lit("cont_busy", int'(o_busy), 0);
    lit("cont_count", int'(o_count), 8);
    lit_frame("cont_word", 16'h1000);

    // Stalled frame: invalid then valid each word.
    step(1'b1, 1'b0, '0); ks = cyc + 1;
    for (int n = 0; n < DEPTH; n++) begin
      step(1'b0, 1'b0, 16'hDEAD);
      step(1'b0, 1'b1, 16'(16'hA0 + n));
    end
    step(1'b0, 1'b0, '0);
    lit("stall_done_edge", last_done_edge - ks, 16);
    lit_frame("stall_word", 16'hA0);

    // Start requests while filling, including on the last-word edge.
    si0 = si_pulses;
    step(1'b1, 1'b0, '0);
    for (int n = 0; n < DEPTH; n++) step((n == 3 || n == 7), 1'b1, 16'(16'hC0 + n));
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    lit("ignored_pulses", si_pulses - si0, 2);
    lit("ignored_busy_after", int'(o_busy), 0);
    lit_frame("ignored_word", 16'hC0);

    // Back-to-back: second start in the done cycle.
    step(1'b1, 1'b0, '0);
    for (int n = 0; n < DEPTH; n++) step(1'b0, 1'b1, 16'(16'hD0 + n));
    step(1'b1, 1'b0, '0);
    @(posedge clk); #2;
    d1 = last_done_edge;
    for (int n = 0; n < DEPTH; n++) step(1'b0, 1'b1, 16'(16'hB0 + n));
    step(1'b0, 1'b0, '0);
    lit("b2b_period", last_done_edge - d1, 9);
    lit_frame("b2b_word", 16'hB0);

    // Reset in the middle of a frame.
    step(1'b1, 1'b0, '0);
    for (int n = 0; n < 5; n++) step(1'b0, 1'b1, 16'(16'hE0 + n));
    @(negedge clk); start = 1'b0; valid = 1'b1; din = 16'hE5; rst = 1'b1;
    @(negedge clk); rst = 1'b0; valid = 1'b0;
    lit("rst_buffer_w0", int'(o_buffer[15:0]), 0);
    lit("rst_buffer_valid", int'(o_buffer_valid), 0);
    lit("rst_count", int'(o_count), 0);
    lit("rst_busy", int'(o_busy), 0);
    step(1'b1, 1'b0, '0);
    for (int n = 0; n < DEPTH; n++) step(1'b0, 1'b1, 16'(16'hF0 + n));
    step(1'b0, 1'b0, '0);
    lit("fresh_valid", int'(o_buffer_valid), 1);
    lit_frame("fresh_word", 16'hF0);
    step(1'b0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
